// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin owner arbiter driving the select lines of a ttl74153 4:1 mux
// Optional macro MUX_ARBITER_TIMEOUT_EN adds a tenure limit that forces release when others wait.
module mux_arbiter #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [3:0] Req,
  output logic [3:0] Grant,
  output logic [1:0] S,
  output logic       Valid,
  output logic       Busy
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 7) begin : g_bad_settle
      $error("mux_arbiter: SETTLE_CYCLES out of range 1..7");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("mux_arbiter: TIMEOUT_CYCLES out of range 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETTLE, OWN} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [2:0] settle_cnt, settle_cnt_nxt;
  logic [3:0] grant_nxt;
  logic [1:0] s_nxt;
  logic       valid_nxt, busy_nxt;
  logic [1:0] pick;
  logic       pick_found;
  logic       owner_req;
  logic       release_now;

`ifdef MUX_ARBITER_TIMEOUT_EN
  logic [7:0] tenure, tenure_nxt;
`endif

  // S always holds the owner index while in SETTLE/OWN
  assign owner_req = Req[S];

  // Round-robin search starting just after the last owner; k=4 wraps to ptr itself
  always_comb begin
    logic [1:0] idx;
    pick       = ptr;
    pick_found = 1'b0;
    idx        = ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!pick_found && Req[idx]) begin
        pick       = idx;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    settle_cnt_nxt = settle_cnt;
    grant_nxt      = Grant;
    s_nxt          = S;
    valid_nxt      = Valid;
    release_now    = 1'b0;
`ifdef MUX_ARBITER_TIMEOUT_EN
    tenure_nxt     = tenure;
`endif
    case (state)
      IDLE: begin
        grant_nxt = 4'b0000;
        valid_nxt = 1'b0;
        if (pick_found) begin
          state_nxt      = SETTLE;
          s_nxt          = pick;
          grant_nxt      = 4'b0001 << pick;
          settle_cnt_nxt = 3'(SETTLE_CYCLES);
        end
      end
      SETTLE: begin
        if (!owner_req) begin
          release_now = 1'b1;
        end else if (settle_cnt <= 3'd1) begin
          state_nxt      = OWN;
          valid_nxt      = 1'b1;
          settle_cnt_nxt = 3'd0;
`ifdef MUX_ARBITER_TIMEOUT_EN
          tenure_nxt     = 8'd1;
`endif
        end else begin
          settle_cnt_nxt = settle_cnt - 3'd1;
        end
      end
      OWN: begin
        if (!owner_req) begin
          release_now = 1'b1;
`ifdef MUX_ARBITER_TIMEOUT_EN
        end else if (tenure == 8'(TIMEOUT_CYCLES)) begin
          // Saturated tenure only yields when someone else is waiting
          if ((Req & ~Grant) != 4'b0000) release_now = 1'b1;
        end else begin
          tenure_nxt = tenure + 8'd1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (release_now) begin
      state_nxt      = IDLE;
      grant_nxt      = 4'b0000;
      valid_nxt      = 1'b0;
      ptr_nxt        = S;
      settle_cnt_nxt = 3'd0;
`ifdef MUX_ARBITER_TIMEOUT_EN
      tenure_nxt     = 8'd0;
`endif
    end
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      ptr        <= 2'd3;
      settle_cnt <= 3'd0;
      Grant      <= 4'b0000;
      S          <= 2'd0;
      Valid      <= 1'b0;
      Busy       <= 1'b0;
`ifdef MUX_ARBITER_TIMEOUT_EN
      tenure     <= 8'd0;
`endif
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      settle_cnt <= settle_cnt_nxt;
      Grant      <= grant_nxt;
      S          <= s_nxt;
      Valid      <= valid_nxt;
      Busy       <= busy_nxt;
`ifdef MUX_ARBITER_TIMEOUT_EN
      tenure     <= tenure_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - directed self-checking bench for mux_arbiter
module tb_mux_arbiter;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [3:0] Req;
  logic [3:0] Grant;
  logic [1:0] S;
  logic       Valid;
  logic       Busy;

  int n_tests = 0;
  int n_fail  = 0;

  mux_arbiter #(.SETTLE_CYCLES(2), .TIMEOUT_CYCLES(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req),
    .Grant(Grant), .S(S), .Valid(Valid), .Busy(Busy)
  );

  initial forever #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic v, input logic b);
    chk({tag, "/grant"}, Grant, g);
    chk({tag, "/s"}, {2'b00, S}, {2'b00, s});
    chk({tag, "/valid"}, {3'b000, Valid}, {3'b000, v});
    chk({tag, "/busy"}, {3'b000, Busy}, {3'b000, b});
  endtask

  initial begin
    logic [3:0] oh;
    int         e;
    Reset_n = 1'b1;
    Req     = 4'b0000;
    #1 Reset_n = 1'b0;
    #1 chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    step();
    chk_out("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);

    // single requester 0: grant, two settle cycles, then valid
    Req = 4'b0001;
    step(); chk_out("r0_grant", 4'b0001, 2'd0, 1'b0, 1'b1);
    step(); chk_out("r0_settle", 4'b0001, 2'd0, 1'b0, 1'b1);
    step(); chk_out("r0_valid", 4'b0001, 2'd0, 1'b1, 1'b1);
    step(); chk_out("r0_own", 4'b0001, 2'd0, 1'b1, 1'b1);
    Req = 4'b0000;
    step(); chk_out("r0_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); chk_out("r0_idle_hold", 4'b0000, 2'd0, 1'b0, 1'b0);

    // fresh reset so round robin starts at requester 0
    Reset_n = 1'b0;
    #2 Reset_n = 1'b1;
    Req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      e  = i % 4;
      oh = 4'b0001 << e;
      step(); chk_out($sformatf("rr%0d_grant", i), oh, 2'(e), 1'b0, 1'b1);
      step(); chk_out($sformatf("rr%0d_settle", i), oh, 2'(e), 1'b0, 1'b1);
      step(); chk_out($sformatf("rr%0d_valid", i), oh, 2'(e), 1'b1, 1'b1);
      Req = oh;
      step(); chk_out($sformatf("rr%0d_others_off", i), oh, 2'(e), 1'b1, 1'b1);
      Req = 4'b1111 & ~oh;
      step(); chk_out($sformatf("rr%0d_turnaround", i), 4'b0000, 2'(e), 1'b0, 1'b0);
      Req = 4'b1111;
    end

    // abort in SETTLE moves the pointer to the aborted owner
    Req = 4'b0100;
    step(); chk_out("ab_grant2", 4'b0100, 2'd2, 1'b0, 1'b1);
    Req = 4'b0010;
    step(); chk_out("ab_abort2", 4'b0000, 2'd2, 1'b0, 1'b0);
    Req = 4'b0110;
    step(); chk_out("ab_grant1", 4'b0010, 2'd1, 1'b0, 1'b1);
    Req = 4'b0101;
    step(); chk_out("ab_abort1", 4'b0000, 2'd1, 1'b0, 1'b0);
    step(); chk_out("ab_ptr1_pick2", 4'b0100, 2'd2, 1'b0, 1'b1);
    Req = 4'b0000;
    step(); chk_out("ab_abort_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // asynchronous reset while owner 3 holds the mux
    Req = 4'b1000;
    step(); chk_out("rst_grant3", 4'b1000, 2'd3, 1'b0, 1'b1);
    step();
    step(); chk_out("rst_own3", 4'b1000, 2'd3, 1'b1, 1'b1);
    #2 Reset_n = 1'b0;
    #1 chk_out("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); chk_out("rst_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    #2 Reset_n = 1'b1;
    step(); chk_out("rst_first_arb", 4'b1000, 2'd3, 1'b0, 1'b1);
    Req = 4'b0000;
    step(); chk_out("rst_drop", 4'b0000, 2'd3, 1'b0, 1'b0);

    // tenure: pointer is 3, requester 0 wins, requester 1 waits
    Req = 4'b0011;
    step(); chk_out("ten_grant0", 4'b0001, 2'd0, 1'b0, 1'b1);
    step();
    step(); chk_out("ten_own1", 4'b0001, 2'd0, 1'b1, 1'b1);
`ifdef MUX_ARBITER_TIMEOUT_EN
    step(); chk_out("ten_own2", 4'b0001, 2'd0, 1'b1, 1'b1);
    step(); chk_out("ten_own3", 4'b0001, 2'd0, 1'b1, 1'b1);
    step(); chk_out("ten_own4", 4'b0001, 2'd0, 1'b1, 1'b1);
    step(); chk_out("ten_forced", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); chk_out("ten_grant1", 4'b0010, 2'd1, 1'b0, 1'b1);
    Req = 4'b0001;
    step(); chk_out("ten_drop1", 4'b0000, 2'd1, 1'b0, 1'b0);
    step(); chk_out("ten_regrant0", 4'b0001, 2'd0, 1'b0, 1'b1);
    step();
    step(); chk_out("ten_valid0", 4'b0001, 2'd0, 1'b1, 1'b1);
    repeat (20) step();
    chk_out("ten_alone_kept", 4'b0001, 2'd0, 1'b1, 1'b1);
`else
    repeat (20) step();
    chk_out("ten_no_limit", 4'b0001, 2'd0, 1'b1, 1'b1);
`endif
    Req = 4'b0000;
    step(); chk_out("final_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
